// File: rtl/run_control.sv
// Board-level run controller for the processor core: boots the core out of reset,
// times execution in cycles, stops the count on the halt opcode or a cycle limit.
module run_control #(
  parameter int                 COUNT_W     = 32,
  parameter logic [5:0]         HALT_OP     = 6'b111111,
  parameter int                 HALT_HOLD   = 1,
  parameter int                 BOOT_CYCLES = 2,
  parameter logic [COUNT_W-1:0] MAX_CYCLES  = '0
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               start,
  input  logic [5:0]         op,
  input  logic [7:0]         led_in,
  input  logic [7:0]         sw,
  output logic               cpu_rstd,
  output logic [COUNT_W-1:0] count,
  output logic               halted,
  output logic               timeout,
  output logic [7:0]         led
);

  localparam int HOLD_W = (HALT_HOLD < 1) ? 1 : $clog2(HALT_HOLD + 1);
  localparam int BOOT_W = (BOOT_CYCLES < 1) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HALT_HOLD);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BOOT = 3'd1,
    RUN  = 3'd2,
    HALT = 3'd3,
    TOUT = 3'd4
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [BOOT_W-1:0]  boot_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_inc;
  logic [COUNT_W-1:0] count_inc;
  logic               halt_det;
  logic               tout_det;
  logic               cpu_rstd_d;
  logic               halted_d;
  logic               timeout_d;
  logic [COUNT_W-1:0] count_d;
  logic [7:0]         led_d;
  logic               unused_sw;

  assign unused_sw = ^sw[5:0];
  assign count_inc = count + COUNT_W'(1);
  assign hold_inc  = hold_cnt + HOLD_W'(1);
  // Halt needs HALT_HOLD back-to-back opcode samples; it takes priority over timeout.
  assign halt_det  = (op == HALT_OP) && (hold_inc == HOLD_LAST);
  assign tout_det  = (MAX_CYCLES != '0) && (count_inc == MAX_CYCLES);

  always_ff @(posedge sysclk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start) next_state = BOOT;
      BOOT:       if (boot_cnt == BOOT_LAST) next_state = RUN;
      RUN: begin
        if (halt_det)      next_state = HALT;
        else if (tout_det) next_state = TOUT;
      end
      HALT, TOUT: if (start) next_state = BOOT;
      default:    next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; flags follow the state one edge later.
  always_comb begin
    count_d    = count;
    cpu_rstd_d = 1'b0;
    halted_d   = 1'b0;
    timeout_d  = 1'b0;
    case (state)
      RUN: begin
        count_d    = count_inc;
        cpu_rstd_d = 1'b1;
      end
      HALT: begin
        if (start) count_d = '0;
        cpu_rstd_d = !start;
        halted_d   = !start;
      end
      TOUT: begin
        if (start) count_d = '0;
        cpu_rstd_d = !start;
        timeout_d  = !start;
      end
      IDLE:    if (start) count_d = '0;
      default: count_d = count;
    endcase
    case (sw[7:6])
      2'b00:   led_d = led_in;
      2'b01:   led_d = count[7:0];
      2'b10:   led_d = count[15:8];
      default: led_d = {halted, timeout, 3'b000, state};
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      boot_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      boot_cnt <= (state == BOOT) ? boot_cnt + BOOT_W'(1) : '0;
      if (state == RUN)
        hold_cnt <= (op == HALT_OP) ? hold_inc : '0;
      else if (next_state == BOOT)
        hold_cnt <= '0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      count    <= '0;
      cpu_rstd <= 1'b0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
      led      <= 8'h00;
    end else begin
      count    <= count_d;
      cpu_rstd <= cpu_rstd_d;
      halted   <= halted_d;
      timeout  <= timeout_d;
      led      <= led_d;
    end
  end

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: three instances cover default settings,
// a two-sample halt filter, and a 16-cycle timeout limit.
module tb_run_control;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  op0, op1, op2;
  logic [7:0]  led_in;
  logic [7:0]  sw;

  logic        cpu_rstd0, halted0, timeout0;
  logic [31:0] count0;
  logic [7:0]  led0;
  logic        cpu_rstd1, halted1, timeout1;
  logic [31:0] count1;
  logic [7:0]  led1;
  logic        cpu_rstd2, halted2, timeout2;
  logic [31:0] count2;
  logic [7:0]  led2;

  int checkCount = 0;
  int errorCount = 0;

  always #5 sysclk = ~sysclk;

  run_control u_dflt (
    .sysclk(sysclk), .rst(rst), .start(start), .op(op0), .led_in(led_in), .sw(sw),
    .cpu_rstd(cpu_rstd0), .count(count0), .halted(halted0), .timeout(timeout0), .led(led0)
  );

  run_control #(.HALT_HOLD(2)) u_hold2 (
    .sysclk(sysclk), .rst(rst), .start(start), .op(op1), .led_in(led_in), .sw(sw),
    .cpu_rstd(cpu_rstd1), .count(count1), .halted(halted1), .timeout(timeout1), .led(led1)
  );

  run_control #(.MAX_CYCLES(32'd16)) u_max (
    .sysclk(sysclk), .rst(rst), .start(start), .op(op2), .led_in(led_in), .sw(sw),
    .cpu_rstd(cpu_rstd2), .count(count2), .halted(halted2), .timeout(timeout2), .led(led2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after an edge and are sampled at the following edges.
  task automatic applyStimulus(input logic s, input logic [5:0] o0, input logic [5:0] o1,
                               input logic [5:0] o2, input int n);
    start = s;
    op0   = o0;
    op1   = o1;
    op2   = o2;
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op0 = '0; op1 = '0; op2 = '0;
    led_in = 8'h5A; sw = 8'hC0;

    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("rst_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    checkOutput("rst_count", count0, 32'd0);
    checkOutput("rst_halted", {31'd0, halted0}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout0}, 32'd0);
    checkOutput("rst_led", {24'd0, led0}, 32'h00);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("idle_status_led", {24'd0, led0}, 32'h00);

    sw = 8'h40;
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("boot_n_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("boot_n1_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    checkOutput("boot_count", count0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("boot_n2_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("run_n3_cpu_rstd", {31'd0, cpu_rstd0}, 32'd1);
    checkOutput("run_first_count", count0, 32'd1);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("run_count5", count0, 32'd5);
    checkOutput("led_count_lag", {24'd0, led0}, 32'd4);

    applyStimulus(0, 0, 0, 0, 5);
    applyStimulus(0, 6'h3F, 0, 0, 1);
    checkOutput("halt_edge_count", count0, 32'd11);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("halt_flag", {31'd0, halted0}, 32'd1);
    checkOutput("halt_count", count0, 32'd11);
    sw = 8'hC0;
    applyStimulus(0, 0, 0, 0, 20);
    checkOutput("halt_frozen_count", count0, 32'd11);
    checkOutput("halt_cpu_rstd", {31'd0, cpu_rstd0}, 32'd1);
    checkOutput("halt_timeout", {31'd0, timeout0}, 32'd0);
    checkOutput("halt_status_led", {24'd0, led0}, 32'h83);

    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("restart_count", count0, 32'd0);
    checkOutput("restart_halted", {31'd0, halted0}, 32'd0);
    checkOutput("restart_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("reboot_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rerun_cpu_rstd", {31'd0, cpu_rstd0}, 32'd1);
    checkOutput("rerun_count", count0, 32'd1);
    applyStimulus(0, 0, 0, 0, 8);
    checkOutput("midrun_count9", count0, 32'd9);

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("midrst_count", count0, 32'd0);
    checkOutput("midrst_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    checkOutput("midrst_halted", {31'd0, halted0}, 32'd0);
    checkOutput("midrst_timeout", {31'd0, timeout0}, 32'd0);
    checkOutput("midrst_led", {24'd0, led0}, 32'h00);
    applyStimulus(1, 0, 0, 0, 1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("rst_prio_cpu_rstd", {31'd0, cpu_rstd0}, 32'd0);
    checkOutput("rst_prio_count", count0, 32'd0);
    checkOutput("rst_prio_led", {24'd0, led0}, 32'h00);

    sw = 8'h00; led_in = 8'hA5;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("led_passthru", {24'd0, led0}, 32'hA5);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 300);
    checkOutput("long_count", count0, 32'd300);
    sw = 8'h80;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("led_count_hi", {24'd0, led0}, 32'h01);
    sw = 8'h40;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("led_count_lo", {24'd0, led0}, 32'h2D);

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    rst = 1'b0; sw = 8'h00;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 2);
    applyStimulus(0, 0, 6'h3F, 0, 1);
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("glitch_no_halt", {31'd0, halted1}, 32'd0);
    checkOutput("glitch_count", count1, 32'd6);
    applyStimulus(0, 0, 6'h3F, 0, 2);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("hold2_halted", {31'd0, halted1}, 32'd1);
    checkOutput("hold2_count", count1, 32'd8);

    applyStimulus(0, 0, 0, 0, 6);
    checkOutput("tout_pre_count", count2, 32'd15);
    checkOutput("tout_pre_flag", {31'd0, timeout2}, 32'd0);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("tout_flag", {31'd0, timeout2}, 32'd1);
    checkOutput("tout_count", count2, 32'd16);
    checkOutput("tout_halted", {31'd0, halted2}, 32'd0);
    sw = 8'hC0;
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tout_status_led", {24'd0, led2}, 32'h44);
    checkOutput("hold2_frozen", count1, 32'd8);

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 0, 15);
    applyStimulus(0, 0, 0, 6'h3F, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("tie_halted", {31'd0, halted2}, 32'd1);
    checkOutput("tie_timeout", {31'd0, timeout2}, 32'd0);
    checkOutput("tie_count", count2, 32'd16);
    applyStimulus(0, 0, 0, 0, 5);
    checkOutput("tie_timeout_late", {31'd0, timeout2}, 32'd0);
    checkOutput("tie_status_led", {24'd0, led2}, 32'h83);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
